fft_frame_config_sink: RTL and testbench

//  AXI-Stream responder for the 24-bit FFT configuration channel. It sits between
//  the audio sample source and the FFT core's data input.
//  It accepts config words, checks NFFT, and holds one word pending.
//  A pending word is applied only at a frame boundary. The block frames the

---
 rtl/fft_frame_config_sink.sv | 172 +++++++++++++++++
 tb/tb_fft_frame_config_sink.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_config_sink.sv
// Config-channel responder and TLAST framer for the FFT input path.
// Holds one validated config word and applies it only at a frame boundary.
module fft_frame_config_sink #(
  parameter int          DATA_W    = 32,
  parameter int          NFFT_MIN  = 7,
  parameter int          NFFT_MAX  = 10,
  parameter int          NFFT_RST  = 10,
  parameter logic [9:0]  SCALE_RST = 10'h155
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [23:0]       s_cfg_tdata,
  input  logic              s_cfg_tvalid,
  output logic              s_cfg_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [4:0]        act_nfft,
  output logic              act_fwd,
  output logic [9:0]        act_scale,
  output logic              cfg_pending,
  output logic              cfg_err,
  output logic              frame_done
);

  logic [4:0]        act_nfft_q, act_nfft_d;
  logic              act_fwd_q, act_fwd_d;
  logic [9:0]        act_scale_q, act_scale_d;
  logic              cfg_pending_q, cfg_pending_d;
  logic [4:0]        pend_nfft_q, pend_nfft_d;
  logic              pend_fwd_q, pend_fwd_d;
  logic [9:0]        pend_scale_q, pend_scale_d;
  logic              cfg_err_q, cfg_err_d;
  logic              frame_done_q, frame_done_d;
  logic [10:0]       idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_last_q, skid_last_d;

  logic              cfg_xfer, in_xfer, last_in, nfft_ok, apply;
  logic [10:0]       frame_last;
  logic [4:0]        cfg_nfft;
  logic              unused_cfg_bits;

  assign unused_cfg_bits = ^{s_cfg_tdata[23:19], s_cfg_tdata[7:5]};

  always_comb begin
    cfg_nfft   = s_cfg_tdata[4:0];
    nfft_ok    = (cfg_nfft >= 5'(NFFT_MIN)) && (cfg_nfft <= 5'(NFFT_MAX));
    cfg_xfer   = s_cfg_tvalid && !cfg_pending_q;
    in_xfer    = s_axis_tvalid && !skid_valid_q;
    frame_last = (11'd1 << act_nfft_q) - 11'd1;
    last_in    = (idx_q == frame_last);
    // Idle at idx 0 is also a boundary, so a word never waits on a stalled source.
    apply      = cfg_pending_q && ((in_xfer && last_in) || (idx_q == 11'd0 && !in_xfer));

    act_nfft_d    = act_nfft_q;
    act_fwd_d     = act_fwd_q;
    act_scale_d   = act_scale_q;
    cfg_pending_d = cfg_pending_q;
    pend_nfft_d   = pend_nfft_q;
    pend_fwd_d    = pend_fwd_q;
    pend_scale_d  = pend_scale_q;
    cfg_err_d     = 1'b0;
    frame_done_d  = 1'b0;
    idx_d         = idx_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_last_d   = skid_last_q;

    if (in_xfer) begin
      idx_d        = last_in ? 11'd0 : idx_q + 11'd1;
      frame_done_d = last_in;
    end

    if (apply) begin
      act_nfft_d    = pend_nfft_q;
      act_fwd_d     = pend_fwd_q;
      act_scale_d   = pend_scale_q;
      cfg_pending_d = 1'b0;
    end else if (cfg_xfer) begin
      if (nfft_ok) begin
        cfg_pending_d = 1'b1;
        pend_nfft_d   = cfg_nfft;
        pend_fwd_d    = s_cfg_tdata[8];
        pend_scale_d  = s_cfg_tdata[18:9];
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (!out_valid_q || m_axis_tready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_xfer;
        if (in_xfer) begin
          out_data_d = s_axis_tdata;
          out_last_d = last_in;
        end
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_axis_tdata;
      skid_last_d  = last_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_nfft_q    <= 5'(NFFT_RST);
      act_fwd_q     <= 1'b1;
      act_scale_q   <= SCALE_RST;
      cfg_pending_q <= 1'b0;
      pend_nfft_q   <= '0;
      pend_fwd_q    <= 1'b0;
      pend_scale_q  <= '0;
      cfg_err_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      idx_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_last_q   <= 1'b0;
    end else begin
      act_nfft_q    <= act_nfft_d;
      act_fwd_q     <= act_fwd_d;
      act_scale_q   <= act_scale_d;
      cfg_pending_q <= cfg_pending_d;
      pend_nfft_q   <= pend_nfft_d;
      pend_fwd_q    <= pend_fwd_d;
      pend_scale_q  <= pend_scale_d;
      cfg_err_q     <= cfg_err_d;
      frame_done_q  <= frame_done_d;
      idx_q         <= idx_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_last_q   <= skid_last_d;
    end
  end

  assign s_cfg_tready  = !cfg_pending_q;
  assign s_axis_tready = !skid_valid_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign act_nfft      = act_nfft_q;
  assign act_fwd       = act_fwd_q;
  assign act_scale     = act_scale_q;
  assign cfg_pending   = cfg_pending_q;
  assign cfg_err       = cfg_err_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_fft_frame_config_sink.sv
// Directed bench for fft_frame_config_sink: framing, config apply timing,
// NFFT rejection, skid stall/backpressure ordering and mid-frame reset.
module tb_fft_frame_config_sink;

  logic        clk;
  logic        rst_n;
  logic [23:0] s_cfg_tdata;
  logic        s_cfg_tvalid;
  logic        s_cfg_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [4:0]  act_nfft;
  logic        act_fwd;
  logic [9:0]  act_scale;
  logic        cfg_pending;
  logic        cfg_err;
  logic        frame_done;

  fft_frame_config_sink dut (
    .clk(clk), .rst_n(rst_n),
    .s_cfg_tdata(s_cfg_tdata), .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tready(s_cfg_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .act_nfft(act_nfft), .act_fwd(act_fwd), .act_scale(act_scale),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned in_seq = 0, exp_cnt = 0;
  int in_beats = 0, out_beats = 0, in_limit = 0;
  int fd_cnt = 0, err_cnt = 0;
  int resync_req = 0, resync_ack = 0;
  bit stall = 1'b0, rand_ready = 1'b0;
  int tlast_q[$];

  function automatic logic [31:0] pat(int unsigned n);
    return 32'(n) ^ 32'hA5A5_0000;
  endfunction

  function automatic int tl_rel(int k, int base_tl, int base_out);
    if (base_tl + k < tlast_q.size()) return tlast_q[base_tl + k] - base_out;
    return -1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source, sink and scoreboard loop: sample at negedge, drive at posedge+1.
  task automatic stream_loop();
    bit in_fire, out_fire, out_is_last, fd_seen, err_seen;
    forever begin
      @(negedge clk);
      in_fire     = s_axis_tvalid && s_axis_tready;
      out_fire    = m_axis_tvalid && m_axis_tready;
      out_is_last = m_axis_tlast;
      fd_seen     = frame_done;
      err_seen    = cfg_err;
      if (out_fire) check_eq("out_data", m_axis_tdata, pat(exp_cnt));
      @(posedge clk);
      #1;
      if (in_fire) begin in_seq++; in_beats++; end
      if (out_fire) begin
        if (out_is_last) tlast_q.push_back(out_beats);
        out_beats++;
        exp_cnt++;
      end
      if (fd_seen) fd_cnt++;
      if (err_seen) err_cnt++;
      if (resync_req != resync_ack) begin
        exp_cnt = in_seq; in_beats = 0; out_beats = 0;
        tlast_q.delete();
        resync_ack = resync_req;
      end
      s_axis_tdata  = pat(in_seq);
      s_axis_tvalid = (in_beats < in_limit);
      m_axis_tready = stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  endtask

  task automatic wait_drained(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_beats == in_limit && out_beats == in_beats) return;
    end
    check_eq(tag, 32'd0, 32'd1);
  endtask

  // Called at a negedge; returns at posedge+1 after the handshake edge.
  task automatic send_cfg(input string tag, input logic [23:0] w, input int budget);
    s_cfg_tdata  = w;
    s_cfg_tvalid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (s_cfg_tready) begin
        @(posedge clk);
        #1;
        s_cfg_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_cfg_tvalid = 1'b0;
    check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input string p);
    check_eq({p, "_m_valid"},  32'(m_axis_tvalid), 32'd0);
    check_eq({p, "_m_last"},   32'(m_axis_tlast),  32'd0);
    check_eq({p, "_m_data"},   m_axis_tdata,       32'd0);
    check_eq({p, "_nfft"},     32'(act_nfft),      32'd10);
    check_eq({p, "_fwd"},      32'(act_fwd),       32'd1);
    check_eq({p, "_scale"},    32'(act_scale),     32'h155);
    check_eq({p, "_pending"},  32'(cfg_pending),   32'd0);
    check_eq({p, "_cfg_err"},  32'(cfg_err),       32'd0);
    check_eq({p, "_fdone"},    32'(frame_done),    32'd0);
    check_eq({p, "_cfg_rdy"},  32'(s_cfg_tready),  32'd1);
    check_eq({p, "_s_rdy"},    32'(s_axis_tready), 32'd1);
  endtask

  initial begin
    int base_out, base_tl, base_fd, base_err, base_in;
    logic [31:0] held;
    rst_n = 1'b0; s_cfg_tdata = '0; s_cfg_tvalid = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    fork stream_loop(); join_none

    // T1: reset state then two default 1024-point frames
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);
    base_out = out_beats; base_tl = tlast_q.size(); base_fd = fd_cnt;
    in_limit += 2048;
    wait_drained("t1_timeout", 4000);
    check_eq("t1_tl_cnt", 32'(tlast_q.size() - base_tl), 32'd2);
    check_eq("t1_tl0", 32'(tl_rel(0, base_tl, base_out)), 32'd1023);
    check_eq("t1_tl1", 32'(tl_rel(1, base_tl, base_out)), 32'd2047);
    check_eq("t1_fdone_cnt", 32'(fd_cnt - base_fd), 32'd2);
    check_eq("t1_nfft", 32'(act_nfft), 32'd10);

    // T2: NFFT=7 word mid-frame waits for the 1024 boundary
    base_out = out_beats; base_tl = tlast_q.size();
    in_limit += 300;
    wait_drained("t2a_timeout", 1000);
    send_cfg("t2_cfg_timeout", 24'h0AA307, 10);
    @(negedge clk);
    check_eq("t2_pend_set", 32'(cfg_pending), 32'd1);
    check_eq("t2_cfg_rdy_low", 32'(s_cfg_tready), 32'd0);
    check_eq("t2_nfft_hold", 32'(act_nfft), 32'd10);
    in_limit += 700;
    wait_drained("t2b_timeout", 2000);
    check_eq("t2_pend_mid", 32'(cfg_pending), 32'd1);
    check_eq("t2_nfft_mid", 32'(act_nfft), 32'd10);
    in_limit += 24 + 128;
    wait_drained("t2c_timeout", 1000);
    check_eq("t2_pend_clr", 32'(cfg_pending), 32'd0);
    check_eq("t2_nfft", 32'(act_nfft), 32'd7);
    check_eq("t2_fwd", 32'(act_fwd), 32'd1);
    check_eq("t2_scale", 32'(act_scale), 32'h151);
    check_eq("t2_tl_cnt", 32'(tlast_q.size() - base_tl), 32'd2);
    check_eq("t2_tl0", 32'(tl_rel(0, base_tl, base_out)), 32'd1023);
    check_eq("t2_tl1", 32'(tl_rel(1, base_tl, base_out)), 32'd1151);

    // T3: out-of-range NFFT words are dropped with a one-cycle error pulse
    base_err = err_cnt;
    @(negedge clk);
    send_cfg("t3a_cfg_timeout", 24'h000105, 10);
    @(negedge clk);
    check_eq("t3_err_nfft5", 32'(cfg_err), 32'd1);
    check_eq("t3_pend_nfft5", 32'(cfg_pending), 32'd0);
    @(negedge clk);
    check_eq("t3_err_clear", 32'(cfg_err), 32'd0);
    send_cfg("t3b_cfg_timeout", 24'h07FF0B, 10);
    @(negedge clk);
    check_eq("t3_err_nfft11", 32'(cfg_err), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("t3_err_cnt", 32'(err_cnt - base_err), 32'd2);
    check_eq("t3_pend", 32'(cfg_pending), 32'd0);
    check_eq("t3_nfft", 32'(act_nfft), 32'd7);
    check_eq("t3_scale", 32'(act_scale), 32'h151);

    // T4: back-to-back words; second waits for the first to apply
    in_limit += 10;
    wait_drained("t4a_timeout", 100);
    base_out = out_beats; base_tl = tlast_q.size();
    in_limit += 118 + 256 + 512;
    send_cfg("t4a_cfg_timeout", 24'h01E008, 10);
    s_cfg_tdata = 24'h07FF09; s_cfg_tvalid = 1'b1;
    @(negedge clk);
    check_eq("t4_pend_a", 32'(cfg_pending), 32'd1);
    check_eq("t4_b_blocked", 32'(s_cfg_tready), 32'd0);
    check_eq("t4_nfft_pre", 32'(act_nfft), 32'd7);
    send_cfg("t4b_cfg_timeout", 24'h07FF09, 400);
    @(negedge clk);
    check_eq("t4_nfft_a", 32'(act_nfft), 32'd8);
    check_eq("t4_fwd_a", 32'(act_fwd), 32'd0);
    check_eq("t4_scale_a", 32'(act_scale), 32'h0F0);
    check_eq("t4_pend_b", 32'(cfg_pending), 32'd1);
    wait_drained("t4b_timeout", 2000);
    check_eq("t4_nfft_b", 32'(act_nfft), 32'd9);
    check_eq("t4_fwd_b", 32'(act_fwd), 32'd1);
    check_eq("t4_scale_b", 32'(act_scale), 32'h3FF);
    check_eq("t4_pend_clr", 32'(cfg_pending), 32'd0);
    check_eq("t4_tl_cnt", 32'(tlast_q.size() - base_tl), 32'd3);
    check_eq("t4_tl0", 32'(tl_rel(0, base_tl, base_out)), 32'd117);
    check_eq("t4_tl1", 32'(tl_rel(1, base_tl, base_out)), 32'd373);
    check_eq("t4_tl2", 32'(tl_rel(2, base_tl, base_out)), 32'd885);

    // T5: random backpressure, then a hard stall filling the skid entry
    base_out = out_beats; base_tl = tlast_q.size();
    rand_ready = 1'b1;
    in_limit += 1024;
    wait_drained("t5_timeout", 8000);
    rand_ready = 1'b0;
    check_eq("t5_count", 32'(out_beats - base_out), 32'd1024);
    check_eq("t5_tl_cnt", 32'(tlast_q.size() - base_tl), 32'd2);
    check_eq("t5_tl0", 32'(tl_rel(0, base_tl, base_out)), 32'd511);
    check_eq("t5_tl1", 32'(tl_rel(1, base_tl, base_out)), 32'd1023);
    base_in = in_beats;
    stall = 1'b1;
    in_limit += 3;
    repeat (6) @(negedge clk);
    check_eq("t5_stall_taken", 32'(in_beats - base_in), 32'd2);
    check_eq("t5_stall_s_rdy", 32'(s_axis_tready), 32'd0);
    check_eq("t5_stall_valid", 32'(m_axis_tvalid), 32'd1);
    check_eq("t5_stall_data", m_axis_tdata, pat(exp_cnt));
    held = m_axis_tdata;
    @(negedge clk);
    check_eq("t5_stall_stable", m_axis_tdata, held);
    stall = 1'b0;
    wait_drained("t5s_timeout", 100);

    // T6: reset at beat 57 of a frame; default framing resumes
    in_limit += 54;
    wait_drained("t6a_timeout", 200);
    rst_n = 1'b0;
    in_limit = 0;
    resync_req++;
    #1;
    check_reset_state("t6");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base_fd = fd_cnt;
    in_limit = 1024;
    wait_drained("t6b_timeout", 3000);
    check_eq("t6_tl_cnt", 32'(tlast_q.size()), 32'd1);
    check_eq("t6_tl0", 32'(tl_rel(0, 0, 0)), 32'd1023);
    check_eq("t6_fdone_cnt", 32'(fd_cnt - base_fd), 32'd1);
    check_eq("t6_nfft", 32'(act_nfft), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
